branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Pipelined, parametrised branch resolution stage for the RV32 core. Accepts one conditional
//  branch per cycle from issue over a valid/ready handshake and evaluates the RISC-V funct3
//  condition. Computes the target, detects mispredicts against the fetch prediction and drives
//  redirect/flush to the front end. Owns a DEPTH-entry table of 2-bit saturating counters; fetch
//  reads it combinationally and it is trained on every resolved branch.
// PARAMETERS
//  XLEN   32  operand/PC width in bits
//  DEPTH  64  predictor entries; power of two, >=2; IDX = $clog2(DEPTH)
// PORTS
//  clk          in   1     core clock; all state on rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  in_valid     in   1     branch op presented
//  in_ready     out  1     stage can accept (= !out_valid || out_ready)
//  in_cond      in   3     funct3: 000 EQ,001 NE,100 LT,101 GE,110 LTU,111 GEU
//  in_a, in_b   in   XLEN  rs1/rs2 operands
//  in_pc        in   XLEN  branch PC
//  in_imm       in   XLEN  sign-extended B-immediate
//  in_pred_tk   in   1     fetch predicted taken
//  in_pred_tgt  in   XLEN  fetch predicted target
//  flush        in   1     kill in-flight op (older exception/redirect)
//  out_valid    out  1     resolution available
//  out_ready    in   1     consumer accepts resolution
//  out_taken    out  1     actual outcome
//  out_mispred  out  1     outcome/target differs from prediction
//  out_redir_pc out  XLEN  correct next PC
//  out_illegal  out  1     cond was 010/011
//  pq_pc        in   XLEN  fetch lookup PC
//  pq_taken     out  1     predicted taken (counter MSB), combinational
// BEHAVIOUR
//  - Reset: out_valid, out_taken, out_mispred, out_illegal = 0; out_redir_pc = 0; all counters = 2'b01.
//  - Accept on in_valid && in_ready. Latency 1: results registered on the accepting edge and held
//    stable while out_valid && !out_ready. Full throughput with out_ready=1.
//  - Signed compares for LT/GE, unsigned for LTU/GEU; EQ/NE bitwise. Illegal cond: taken=0,
//    illegal=1, no table update.
//  - target = in_pc + in_imm and fall = in_pc + 4, both mod 2^XLEN (wrap, no flag).
//  - redir_pc = taken ? target : fall.
//  - mispred = (taken != pred_tk) || (taken && target != pred_tgt).
//  - Index = pc[IDX+1:2]. Counter update at the accepting edge: taken -> sat-inc (max 11),
//    not taken -> sat-dec (min 00).
//  - pq_taken returns the pre-update value when pq and update indices collide in the same cycle.
//  - flush: clears out_valid next edge. If the same cycle also accepts an op, that op is discarded
//    and its table update suppressed. Flush has priority over out_ready.
//  - Async reset mid-operation drops any pending result immediately.
// CONFIGURATION
//  BRU_PERF_EN defined: adds outputs perf_branches[31:0] and perf_mispred[31:0].
//   - Counters count committed resolutions (out_valid && out_ready && !flush).
//   - Wrap at 2^32; reset to 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package bru_pkg: funct3 condition localparams, counter-state localparams (SNT,WNT,WT,ST),
//  reset counter value.
//  One sub-module bru_bht (counter array, comb read port, sync sat-update port). Compare/target
//  logic stays in the top module.
// TESTING
//  1. BEQ a=5,b=5,pc=0x100,imm=0x20,pred_tk=1,tgt=0x120 -> taken=1,mispred=0,redir=0x120 next cycle.
//  2. BLT a=0xFFFFFFFF,b=1 -> taken=1; BLTU same operands -> taken=0; pred_tk=1 -> mispred=1,
//     redir=pc+4.
//  3. pc=0xFFFFFFF0,imm=0x20,BNE a!=b -> redir=0x00000010 (wrap).
//  4. Train index 3 with four taken branches from reset -> pq_taken at pc=0xC goes 0,1,1,1;
//     then two not-taken -> 1,0.
//  5. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; release -> next op
//     accepted.
//  6. flush with simultaneous accept -> out_valid=0 next cycle, counter unchanged; cond=010 ->
//     illegal=1.

Source files
------------

// File: rtl/bru_pkg.sv
// bru_pkg: condition codes, 2-bit counter states and the saturating counter update
// shared by the branch resolution stage and its predictor table.
package bru_pkg;
    localparam logic [2:0] COND_EQ  = 3'b000;
    localparam logic [2:0] COND_NE  = 3'b001;
    localparam logic [2:0] COND_LT  = 3'b100;
    localparam logic [2:0] COND_GE  = 3'b101;
    localparam logic [2:0] COND_LTU = 3'b110;
    localparam logic [2:0] COND_GEU = 3'b111;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;
    localparam logic [1:0] CTR_RESET = WNT;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic tk);
        return tk ? ((c == ST) ? ST : c + 2'd1) : ((c == SNT) ? SNT : c - 2'd1);
    endfunction
endpackage

// File: rtl/bru_bht.sv
// bru_bht: DEPTH-entry table of 2-bit saturating counters with one combinational
// read port and one synchronous update port; reads see the pre-update value.
module bru_bht
    import bru_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int IDX = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [IDX-1:0] rd_idx,
    output logic           rd_taken,
    input  logic           upd_en,
    input  logic [IDX-1:0] upd_idx,
    input  logic           upd_taken
);
    logic [1:0] cnt_q [DEPTH];
    logic [1:0] cnt_d [DEPTH];

    assign rd_taken = cnt_q[rd_idx][1];

    always_comb begin
        cnt_d = cnt_q;
        if (upd_en) cnt_d[upd_idx] = ctr_next(cnt_q[upd_idx], upd_taken);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CTR_RESET;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: one-cycle branch resolution with mispredict detection and a
// 2-bit counter predictor. Define BRU_PERF_EN to add committed branch/mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 64,
    localparam int IDX = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_cond,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_tk,
    input  logic [XLEN-1:0] in_pred_tgt,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_mispred,
    output logic [XLEN-1:0] out_redir_pc,
    output logic            out_illegal,
    input  logic [XLEN-1:0] pq_pc,
    output logic            pq_taken
`ifdef BRU_PERF_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispred
`endif
);
    logic            out_valid_q, out_valid_d;
    logic            out_taken_q, out_taken_d;
    logic            out_mispred_q, out_mispred_d;
    logic            out_illegal_q, out_illegal_d;
    logic [XLEN-1:0] out_redir_q, out_redir_d;
    logic            eq, lt, ltu, illegal, taken, mispred, accept, keep;
    logic [XLEN-1:0] target, fall;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign keep     = accept && !flush;

    always_comb begin
        eq      = in_a == in_b;
        lt      = $signed(in_a) < $signed(in_b);
        ltu     = in_a < in_b;
        illegal = in_cond[2:1] == 2'b01;
        taken   = (in_cond == COND_EQ)  ? eq   :
                  (in_cond == COND_NE)  ? !eq  :
                  (in_cond == COND_LT)  ? lt   :
                  (in_cond == COND_GE)  ? !lt  :
                  (in_cond == COND_LTU) ? ltu  :
                  (in_cond == COND_GEU) ? !ltu : 1'b0;
        target  = in_pc + in_imm;
        fall    = in_pc + XLEN'(4);
        mispred = (taken != in_pred_tk) || (taken && target != in_pred_tgt);
        // flush wins over both a new accept and the consumer draining the result
        out_valid_d   = flush ? 1'b0 : accept ? 1'b1 : out_valid_q && !out_ready;
        out_taken_d   = keep ? taken : out_taken_q;
        out_mispred_d = keep ? mispred : out_mispred_q;
        out_illegal_d = keep ? illegal : out_illegal_q;
        out_redir_d   = keep ? (taken ? target : fall) : out_redir_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_taken_q   <= 1'b0;
            out_mispred_q <= 1'b0;
            out_illegal_q <= 1'b0;
            out_redir_q   <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_taken_q   <= out_taken_d;
            out_mispred_q <= out_mispred_d;
            out_illegal_q <= out_illegal_d;
            out_redir_q   <= out_redir_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_taken    = out_taken_q;
    assign out_mispred  = out_mispred_q;
    assign out_illegal  = out_illegal_q;
    assign out_redir_pc = out_redir_q;

    bru_bht #(.DEPTH(DEPTH)) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (IDX'(pq_pc >> 2)),
        .rd_taken (pq_taken),
        .upd_en   (keep && !illegal),
        .upd_idx  (IDX'(in_pc >> 2)),
        .upd_taken(taken)
    );

`ifdef BRU_PERF_EN
    logic [31:0] perf_br_q, perf_br_d, perf_mp_q, perf_mp_d;
    logic        commit;

    assign commit = out_valid_q && out_ready && !flush;

    always_comb begin
        perf_br_d = perf_br_q + 32'(commit);
        perf_mp_d = perf_mp_q + 32'(commit && out_mispred_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else begin
            perf_br_q <= perf_br_d;
            perf_mp_q <= perf_mp_d;
        end
    end

    assign perf_branches = perf_br_q;
    assign perf_mispred  = perf_mp_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed scenarios plus randomized traffic checked against
// a cycle-level reference model of the resolution stage and predictor table.
module tb_branch_resolve_unit;
    localparam int XLEN  = 32;
    localparam int DEPTH = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0, in_ready;
    logic [2:0]      in_cond = '0;
    logic [XLEN-1:0] in_a = '0, in_b = '0, in_pc = '0, in_imm = '0, in_pred_tgt = '0;
    logic            in_pred_tk = 1'b0, flush = 1'b0;
    logic            out_valid, out_ready = 1'b1, out_taken, out_mispred, out_illegal;
    logic [XLEN-1:0] out_redir_pc, pq_pc = '0;
    logic            pq_taken;

    branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_cond(in_cond),
        .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm),
        .in_pred_tk(in_pred_tk), .in_pred_tgt(in_pred_tgt), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_mispred(out_mispred), .out_redir_pc(out_redir_pc), .out_illegal(out_illegal),
        .pq_pc(pq_pc), .pq_taken(pq_taken)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model state
    bit          mv, mt, mm, mi;
    logic [31:0] mr;
    int          ctr [DEPTH];

    task automatic model_reset();
        mv = 0; mt = 0; mm = 0; mi = 0; mr = '0;
        foreach (ctr[i]) ctr[i] = 1;
    endtask

    function automatic bit ref_taken(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input bit v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm, input bit ptk, input logic [31:0] ptgt);
        in_valid = v; in_cond = c; in_a = a; in_b = b; in_pc = pc; in_imm = imm;
        in_pred_tk = ptk; in_pred_tgt = ptgt;
    endtask

    // one clock: pre-edge checks, model evaluation, edge, post-edge checks
    task automatic step();
        bit acc, t, upd, nv;
        logic [31:0] tgt;
        int idx;
        #1;
        check("in_ready", in_ready, 32'(!mv || out_ready));
        check("pq_taken", pq_taken, 32'(ctr[int'((pq_pc >> 2) % DEPTH)] >= 2));
        acc = in_valid && (!mv || out_ready);
        upd = 0;
        t = 0;
        idx = int'((in_pc >> 2) % DEPTH);
        nv = flush ? 0 : acc ? 1 : (mv && !out_ready);
        if (acc && !flush) begin
            mi  = (in_cond == 3'd2) || (in_cond == 3'd3);
            t   = ref_taken(in_cond, in_a, in_b);
            tgt = in_pc + in_imm;
            mt  = t;
            mr  = t ? tgt : in_pc + 32'd4;
            mm  = (t != in_pred_tk) || (t && tgt != in_pred_tgt);
            upd = !mi;
        end
        @(posedge clk);
        mv = nv;
        if (upd) ctr[idx] = t ? (ctr[idx] < 3 ? ctr[idx] + 1 : 3) : (ctr[idx] > 0 ? ctr[idx] - 1 : 0);
        #1;
        check("out_valid", out_valid, 32'(mv));
        if (mv) begin
            check("out_taken", out_taken, 32'(mt));
            check("out_mispred", out_mispred, 32'(mm));
            check("out_redir_pc", out_redir_pc, mr);
            check("out_illegal", out_illegal, 32'(mi));
        end
    endtask

    logic [31:0] held;
    bit          exp_pq [4] = '{0, 1, 1, 1};

    initial begin
        model_reset();
        #12;
        check("rst_valid", out_valid, 0);
        check("rst_taken", out_taken, 0);
        check("rst_mispred", out_mispred, 0);
        check("rst_illegal", out_illegal, 0);
        check("rst_redir", out_redir_pc, 0);
        check("rst_pq", pq_taken, 0);
        rst_n = 1'b1;

        // BEQ taken, correctly predicted
        drive(1, 3'd0, 5, 5, 32'h100, 32'h20, 1, 32'h120);
        step();
        check("beq_taken", out_taken, 1);
        check("beq_mispred", out_mispred, 0);
        check("beq_redir", out_redir_pc, 32'h120);

        // signed vs unsigned compare
        drive(1, 3'd4, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, 1, 32'h240);
        step();
        check("blt_taken", out_taken, 1);
        drive(1, 3'd6, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, 1, 32'h240);
        step();
        check("bltu_taken", out_taken, 0);
        check("bltu_mispred", out_mispred, 1);
        check("bltu_redir", out_redir_pc, 32'h204);

        // target wraps
        drive(1, 3'd1, 1, 2, 32'hFFFF_FFF0, 32'h20, 0, 0);
        step();
        check("wrap_redir", out_redir_pc, 32'h10);

        // train index 3
        in_valid = 0;
        step();
        pq_pc = 32'hC;
        for (int k = 0; k < 4; k++) begin
            drive(1, 3'd0, 7, 7, 32'hC, 32'h8, 1, 32'h14);
            #1 check("train_tk_pq", pq_taken, 32'(exp_pq[k]));
            step();
        end
        drive(1, 3'd0, 7, 8, 32'hC, 32'h8, 1, 32'h14);
        step();
        check("train_nt1_pq", pq_taken, 1);
        step();
        check("train_nt2_pq", pq_taken, 0);

        // backpressure stall
        drive(1, 3'd5, 9, 3, 32'h300, 32'h10, 0, 0);
        step();
        held = out_redir_pc;
        out_ready = 0;
        drive(1, 3'd0, 1, 2, 32'h400, 32'h10, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_ready", in_ready, 0);
            check("stall_hold", out_redir_pc, held);
        end
        out_ready = 1;
        step();
        check("release_redir", out_redir_pc, 32'h404);

        // flush with simultaneous accept
        drive(1, 3'd0, 3, 3, 32'h40, 32'h8, 1, 32'h48);
        flush = 1;
        step();
        flush = 0;
        in_valid = 0;
        check("flush_valid", out_valid, 0);
        pq_pc = 32'h40;
        #1 check("flush_pq", pq_taken, 0);
        drive(1, 3'd2, 3, 3, 32'h44, 32'h8, 0, 0);
        step();
        check("illegal_flag", out_illegal, 1);
        check("illegal_taken", out_taken, 0);

        // async reset drops a pending result
        out_ready = 0;
        drive(1, 3'd0, 1, 1, 32'h80, 32'h8, 0, 0);
        step();
        in_valid = 0;
        #3 rst_n = 0;
        #1 check("async_rst_valid", out_valid, 0);
        model_reset();
        #1 rst_n = 1;
        out_ready = 1;
        step();

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            logic [31:0] a, pc, imm;
            a   = $urandom;
            pc  = {$urandom_range(0, 3) == 0 ? $urandom : 32'h0, 24'h0} | {$urandom_range(0, 255), 2'b00};
            imm = $urandom_range(0, 1) ? 32'($signed(13'($urandom) & 13'h1FFE)) : $urandom;
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a,
                  $urandom_range(0, 2) == 0 ? a : $urandom, pc, imm,
                  1'($urandom), $urandom_range(0, 1) ? pc + imm : $urandom);
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 7) == 0;
            pq_pc     = $urandom_range(0, 1) ? pc : 32'($urandom_range(0, 1023));
            step();
        end
        flush = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
